// File: rtl/uxn_device_pkg.sv
// Shared types and constants for the Varvara device RAM and its arbiters.
package uxn_device_pkg;

    localparam int DEV_AW = 8;
    localparam int DEV_DW = 8;

    // One requester's access as seen by the RAM port.
    typedef struct packed {
        logic              we;
        logic [DEV_AW-1:0] addr;
        logic [DEV_DW-1:0] wdata;
    } dev_req_t;

    // Tag that follows a read down the RAM pipeline.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } rd_tag_t;

endpackage

// File: rtl/uxn_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping from N-1 back to 0. Returns a one-hot grant and its index.
module uxn_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    // Scan N positions starting at ptr; the first requester found wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            for (int m = 0; m < N; m++) begin
                if (m == j && !any && req[m]) begin
                    any    = 1'b1;
                    gnt[m] = 1'b1;
                    idx    = PW'(m);
                end
            end
        end
    end

endmodule

// File: rtl/uxn_device_ram_arbiter.sv
// Arbiter for port A of the 256x8 Varvara device RAM.
// Optional build macro UXN_DEV_ARB_CPU_PRIO_EN: requester 0 (CPU) wins over
// round-robin whenever it requests, unless another requester holds a lock.
//
// Handshake: a requester raises req with we/addr/wdata/lock and holds them
// until gnt is seen in the same cycle; the access is accepted in that cycle
// and the requester may change its inputs the following cycle. A read comes
// back two cycles after its grant as an rvalid pulse on that requester's bit,
// with rdata carrying the RAM output in the same cycle.
module uxn_device_ram_arbiter
    import uxn_device_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = DEV_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [7:0]            rdata,
    output logic [AW-1:0]         ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_q
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic               owner_valid_q, owner_valid_d;
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [7:0]         ram_wdata_q, ram_wdata_d;
    rd_tag_t            tag1_q, tag1_d;
    rd_tag_t            tag2_q, tag2_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;
    logic               owner_hit;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    dev_req_t           sel;

    uxn_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A lock only holds while its owner keeps requesting.
    assign owner_hit = owner_valid_q && req[owner_q];

    // Choose the winner: locked owner first, then (optionally) CPU, then RR.
    always_comb begin
        gnt_idx = pick_idx;
        gnt_any = pick_any;
        if (owner_hit) begin
            gnt_idx = owner_q;
            gnt_any = 1'b1;
        end
`ifdef UXN_DEV_ARB_CPU_PRIO_EN
        else if (req[0]) begin
            gnt_idx = '0;
            gnt_any = 1'b1;
        end
`endif
        gnt = '0;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                gnt[i]    = gnt_any;
                sel.we    = req_we[i];
                sel.addr  = req_addr[i*AW +: AW];
                sel.wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // Next-state: load the RAM port, advance the pointer, track the lock and
    // push a read tag into the two-stage pipeline.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        owner_valid_d = owner_hit;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_we_d      = 1'b0;
        tag1_d        = '0;
        tag2_d        = tag1_q;
        if (gnt_any) begin
            ram_addr_d    = sel.addr;
            ram_wdata_d   = sel.wdata;
            ram_we_d      = sel.we;
            owner_d       = gnt_idx;
            owner_valid_d = req_lock[gnt_idx];
            tag1_d.valid  = !sel.we;
            tag1_d.id     = 3'(gnt_idx);
`ifdef UXN_DEV_ARB_CPU_PRIO_EN
            if (gnt_idx != '0)
`endif
                rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // State registers; reset drops in-flight reads and any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            tag1_q        <= '0;
            tag2_q        <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
        end
    end

    // Return path: the registered second-stage tag selects the owner and
    // qualifies the RAM output, which is valid in that same cycle.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag2_q.id == 3'(i)) rvalid[i] = tag2_q.valid;
        end
        if (tag2_q.valid) rdata = ram_q;
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_uxn_device_ram_arbiter.sv
// Directed bench for uxn_device_ram_arbiter with a synchronous write-through
// RAM model on port A.
module tb_uxn_device_ram_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_lock, req_we;
    logic [N*8-1:0] req_addr, req_wdata;
    logic [N-1:0]   gnt, rvalid;
    logic [7:0]     rdata, ram_addr, ram_wdata, ram_q;
    logic           ram_we;

    logic           r_req[N], r_lock[N], r_we[N];
    logic [7:0]     r_addr[N], r_wdata[N];

    logic [7:0]     mem[256];
    logic           pl_we;
    logic [7:0]     pl_addr, pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req[g]              = r_req[g];
        assign req_lock[g]         = r_lock[g];
        assign req_we[g]           = r_we[g];
        assign req_addr[g*8 +: 8]  = r_addr[g];
        assign req_wdata[g*8 +: 8] = r_wdata[g];
    end

    // RAM model: one-cycle read latency, new data on q during a write.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_q         <= ram_wdata;
        end else begin
            ram_q <= mem[ram_addr];
        end
    end

    uxn_device_ram_arbiter #(.NUM_REQ(N), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_lock[i] = 1'b0; r_we[i] = 1'b0;
            r_addr[i] = 8'h00; r_wdata[i] = 8'h00;
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic lock,
                           input logic [7:0] addr, input logic [7:0] wd);
        r_req[i] = 1'b1; r_we[i] = we; r_lock[i] = lock;
        r_addr[i] = addr; r_wdata[i] = wd;
    endtask

    task automatic drop_req(input int i);
        r_req[i] = 1'b0; r_lock[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
        clear_reqs();
        preload(8'h2A, 8'h5C);
        for (int i = 0; i < N; i++) preload(8'(8'h40 + i), 8'(8'hA0 + i));
        preload(8'h90, 8'h00);
        @(negedge clk);
        check("reset_ram_addr",  32'(ram_addr),  32'h0);
        check("reset_ram_we",    32'(ram_we),    32'h0);
        check("reset_ram_wdata", 32'(ram_wdata), 32'h0);
        check("reset_rvalid",    32'(rvalid),    32'h0);
        check("reset_rdata",     32'(rdata),     32'h0);
        tick();
        rst = 1'b0;

        // Single read from requester 1.
        set_req(1, 1'b0, 1'b0, 8'h2A, 8'h00);
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'b0010);
        tick();
        clear_reqs();
        @(negedge clk);
        check("single_ram_addr", 32'(ram_addr), 32'h2A);
        check("single_ram_we",   32'(ram_we),   32'h0);
        check("single_rvalid_t1", 32'(rvalid),  32'h0);
        tick();
        @(negedge clk);
        check("single_rvalid", 32'(rvalid), 32'b0010);
        check("single_rdata",  32'(rdata),  32'h5C);
        tick();

        // Round-robin with all four reading.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) clear_reqs();
            @(negedge clk);
            if (k < 8) check($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(1) << (k % 4));
            if (k >= 2) begin
                check($sformatf("rr_rvalid_%0d", k), 32'(rvalid), 32'(1) << ((k - 2) % 4));
                check($sformatf("rr_rdata_%0d", k),  32'(rdata),  32'(8'hA0 + ((k - 2) % 4)));
            end else begin
                check($sformatf("rr_rvalid_%0d", k), 32'(rvalid), 32'h0);
            end
            tick();
        end

        // Locked short write by requester 2 while 0 and 3 compete.
        do_reset();
        set_req(2, 1'b1, 1'b1, 8'h80, 8'h12);
        @(negedge clk);
        check("lock_gnt_c0", 32'(gnt), 32'b0100);
        tick();
        set_req(2, 1'b1, 1'b0, 8'h81, 8'h34);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(3, 1'b0, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        check("lock_gnt_c1",      32'(gnt),      32'b0100);
        check("lock_ram_we_c1",   32'(ram_we),   32'h1);
        check("lock_ram_addr_c1", 32'(ram_addr), 32'h80);
        tick();
        drop_req(2);
        @(negedge clk);
        check("lock_gnt_c2",       32'(gnt),       32'b1000);
        check("lock_ram_addr_c2",  32'(ram_addr),  32'h81);
        check("lock_ram_wdata_c2", 32'(ram_wdata), 32'h34);
        tick();
        drop_req(3);
        @(negedge clk);
        check("lock_gnt_c3", 32'(gnt), 32'b0001);
        tick();
        clear_reqs();
        tick();
        tick();
        check("lock_mem_80", 32'(mem[8'h80]), 32'h12);
        check("lock_mem_81", 32'(mem[8'h81]), 32'h34);

        // Write then read the same address back-to-back.
        do_reset();
        set_req(1, 1'b1, 1'b0, 8'h10, 8'hAB);
        @(negedge clk);
        check("wtr_gnt_w", 32'(gnt), 32'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("wtr_gnt_r",  32'(gnt),    32'b0010);
        check("wtr_ram_we", 32'(ram_we), 32'h1);
        tick();
        clear_reqs();
        @(negedge clk);
        check("wtr_no_rvalid", 32'(rvalid), 32'h0);
        tick();
        @(negedge clk);
        check("wtr_rvalid", 32'(rvalid), 32'b0010);
        check("wtr_rdata",  32'(rdata),  32'hAB);
        tick();

        // Asynchronous reset with a write registered and a read in flight.
        do_reset();
        set_req(3, 1'b1, 1'b0, 8'h90, 8'h77);
        @(negedge clk);
        check("rst_gnt_w", 32'(gnt), 32'b1000);
        tick();
        clear_reqs();
        set_req(1, 1'b0, 1'b0, 8'h2A, 8'h00);
        @(negedge clk);
        check("rst_gnt_r",      32'(gnt),    32'b0010);
        check("rst_pre_ram_we", 32'(ram_we), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_ram_we_now", 32'(ram_we), 32'h0);
        check("rst_rvalid_now", 32'(rvalid), 32'h0);
        clear_reqs();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_rvalid_%0d", k), 32'(rvalid), 32'h0);
            tick();
        end
        check("rst_mem_90", 32'(mem[8'h90]), 32'h00);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        check("rst_next_gnt", 32'(gnt), 32'b0001);
        tick();

        // CPU and requester 3 both requesting continuously.
        do_reset();
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(3, 1'b0, 1'b0, 8'h01, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef UXN_DEV_ARB_CPU_PRIO_EN
            check($sformatf("prio_gnt_%0d", k), 32'(gnt), 32'b0001);
`else
            check($sformatf("prio_gnt_%0d", k), 32'(gnt), (k % 2 == 0) ? 32'b0001 : 32'b1000);
`endif
            tick();
        end
        clear_reqs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
